// File: rtl/fp_pkg.sv
// Constants and FSM state encoding shared by the single-precision FP blocks.
package fp_pkg;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIVIDE = 3'd2,
    NORM   = 3'd3,
    PACK   = 3'd4
  } state_t;

endpackage

// File: rtl/fp_divider_if.sv
// Request/result bundle for fp_divider.
interface fp_divider_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        flag_done;
  logic        div_by_zero;
  logic [31:0] result;

  modport master (
    output start, a, b,
    input  busy, flag_done, div_by_zero, result
  );

  modport slave (
    input  start, a, b,
    output busy, flag_done, div_by_zero, result
  );
endinterface

// File: rtl/fp_div_step.sv
// One restoring-division iteration: conditional subtract, then shift left.
module fp_div_step (
  input  logic [25:0] rem,
  input  logic [23:0] mb,
  output logic        qbit,
  output logic [25:0] rem_next
);
  logic [25:0] diff;

  // Subtract when the divisor fits, then shift the partial remainder up
  always_comb begin
    qbit     = (rem >= {2'b00, mb});
    diff     = rem - {2'b00, mb};
    rem_next = qbit ? {diff[24:0], 1'b0} : {rem[24:0], 1'b0};
  end
endmodule

// File: rtl/fp_divider.sv
// Multi-cycle IEEE-754 single-precision divider; fixed 28-edge latency,
// truncating, denormals flushed to zero.
module fp_divider
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fp_divider_if.slave  bus
);

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        mb_q, mb_d;
  logic [25:0]        rem_q, rem_d;
  logic [24:0]        q_q, q_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [22:0]        mant_q, mant_d;
  logic               nan_q, nan_d;
  logic               a_zero_q, a_zero_d;
  logic               b_zero_q, b_zero_d;
  logic               flag_done_q, flag_done_d;
  logic               div_by_zero_q, div_by_zero_d;
  logic [31:0]        result_q, result_d;

  logic [7:0]         ea, eb;
  logic [23:0]        ma, mb;
  logic               step_qbit;
  logic [25:0]        step_rem;

  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign ma = (ea == 8'd0) ? '0 : {1'b1, a_q[22:0]};
  assign mb = (eb == 8'd0) ? '0 : {1'b1, b_q[22:0]};

  fp_div_step u_step (
    .rem      (rem_q),
    .mb       (mb_q),
    .qbit     (step_qbit),
    .rem_next (step_rem)
  );

  // Next-state and datapath updates for every FSM phase
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    mb_d          = mb_q;
    rem_d         = rem_q;
    q_d           = q_q;
    cnt_d         = cnt_q;
    mant_d        = mant_q;
    nan_d         = nan_q;
    a_zero_d      = a_zero_q;
    b_zero_d      = b_zero_q;
    flag_done_d   = 1'b0;
    div_by_zero_d = div_by_zero_q;
    result_d      = result_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d   = a_q[31] ^ b_q[31];
        exp_d    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(BIAS));
        mb_d     = mb;
        rem_d    = {2'b00, ma};
        q_d      = '0;
        cnt_d    = '0;
        nan_d    = (ea == EXP_MAX) || (eb == EXP_MAX);
        a_zero_d = (ea == 8'd0);
        b_zero_d = (eb == 8'd0);
        state_d  = DIVIDE;
      end
      DIVIDE: begin
        rem_d = step_rem;
        q_d   = {q_q[23:0], step_qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) state_d = NORM;
      end
      NORM: begin
        // The leading one is implicit, so only the 23 fraction bits are kept
        if (q_q[24]) begin
          mant_d = q_q[23:1];
        end else begin
          mant_d = q_q[22:0];
          exp_d  = exp_q - 10'sd1;
        end
        state_d = PACK;
      end
      PACK: begin
        flag_done_d   = 1'b1;
        div_by_zero_d = 1'b0;
        if (nan_q || (a_zero_q && b_zero_q)) begin
          result_d = QNAN;
        end else if (b_zero_q) begin
          result_d      = {sign_q, EXP_MAX, 23'b0};
          div_by_zero_d = 1'b1;
        end else if (a_zero_q) begin
          result_d = '0;
        end else if (exp_q >= 10'sd255) begin
          result_d = {sign_q, EXP_MAX, 23'b0};
        end else if (exp_q <= 10'sd0) begin
          result_d = '0;
        end else begin
          result_d = {sign_q, exp_q[7:0], mant_q};
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      mb_q          <= '0;
      rem_q         <= '0;
      q_q           <= '0;
      cnt_q         <= '0;
      mant_q        <= '0;
      nan_q         <= 1'b0;
      a_zero_q      <= 1'b0;
      b_zero_q      <= 1'b0;
      flag_done_q   <= 1'b0;
      div_by_zero_q <= 1'b0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      mb_q          <= mb_d;
      rem_q         <= rem_d;
      q_q           <= q_d;
      cnt_q         <= cnt_d;
      mant_q        <= mant_d;
      nan_q         <= nan_d;
      a_zero_q      <= a_zero_d;
      b_zero_q      <= b_zero_d;
      flag_done_q   <= flag_done_d;
      div_by_zero_q <= div_by_zero_d;
      result_q      <= result_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.flag_done   = flag_done_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.result      = result_q;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: vector table + scoreboard queue,
// plus directed sequences for start-while-busy and mid-operation reset.
module tb_fp_divider;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
  } exp_t;

  logic clk;
  logic reset;
  fp_divider_if bus ();

  fp_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: each completion pops the oldest expectation
  always @(negedge clk) begin
    if (!reset && bus.flag_done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  // Issue one operation, expect completion 28 edges after acceptance
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic dbz);
    int k;
    exp_t e;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    e.res = res;
    e.dbz = dbz;
    sb.push_back(e);
    #1 bus.start = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h1234_5678;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      #1 k++;
      if (bus.flag_done === 1'b1) break;
    end
    chk("latency", k, 28);
    @(posedge clk);
    #1 chk("done_width", {31'd0, bus.flag_done}, 32'd0);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int k;
    int done_before;
    logic busy_ok;

    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0};
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0};
    vecs[2]  = '{32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, 1'b0};
    vecs[3]  = '{32'h40A0_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1};
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0};
    vecs[5]  = '{32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0};
    vecs[6]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0};
    vecs[7]  = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{32'hBF80_0000, 32'hBF80_0000, 32'h3F80_0000, 1'b0};
    vecs[9]  = '{32'h3F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{32'hC0A0_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1};
    vecs[12] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0};
    vecs[13] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0};
    vecs[14] = '{32'h4110_0000, 32'h4040_0000, 32'h4040_0000, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.flag_done}, 32'd0);
    chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz);
    end

    // start re-pulsed mid-DIVIDE with other operands must be ignored
    done_before = done_cnt;
    @(negedge clk);
    bus.a = 32'h40C0_0000;
    bus.b = 32'h4000_0000;
    bus.start = 1'b1;
    @(posedge clk);
    begin
      exp_t e;
      e.res = 32'h4040_0000;
      e.dbz = 1'b0;
      sb.push_back(e);
    end
    #1 bus.start = 1'b0;
    busy_ok = 1'b1;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      #1 k++;
      if (bus.flag_done === 1'b1) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (k == 5) begin
        bus.a = 32'h3F80_0000;
        bus.b = 32'h4040_0000;
        bus.start = 1'b1;
      end
      if (k == 7) bus.start = 1'b0;
    end
    chk("repulse_latency", k, 28);
    chk("repulse_busy", {31'd0, busy_ok}, 32'd1);
    repeat (40) @(posedge clk);
    chk("repulse_done_count", done_cnt - done_before, 1);

    // reset during DIVIDE aborts silently
    done_before = done_cnt;
    @(negedge clk);
    bus.a = 32'h40C0_0000;
    bus.b = 32'h4000_0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    chk("abort_done", {31'd0, bus.flag_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (35) @(posedge clk);
    chk("abort_no_done", done_cnt - done_before, 0);
    run_op(32'h4110_0000, 32'h4040_0000, 32'h4040_0000, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- a  in  32  IEEE-754 single dividend
- b  in  32  IEEE-754 single divisor
- busy  out  1  high in every state except IDLE
- flag_done  out  1  one-cycle pulse, result valid
- div_by_zero  out  1  set with flag_done when b is zero and a is finite nonzero
- result  out  32  quotient a/b

Function
REQ-003 The FSM SHALL have these states: IDLE, UNPACK, DIVIDE, NORM, PACK.
- IDLE->UNPACK on start=1.
- UNPACK->DIVIDE after 1 cycle.
- DIVIDE->NORM after 25 cycles.
- NORM->PACK after 1 cycle.
- PACK->IDLE after 1 cycle.
REQ-004 On the accepting edge, the block SHALL capture a and b into internal registers; later changes to a and b have no effect on the operation in progress.
REQ-005 start while busy SHALL be ignored, with no queuing.
REQ-006 Latency SHALL be fixed for all operands, including special cases: result and flag_done register on the 28th rising edge after the accepting edge.
REQ-007 flag_done SHALL be high for exactly one cycle; result SHALL hold its value until the next PACK or reset; div_by_zero SHALL be updated only at PACK.
REQ-008 UNPACK SHALL form each 24-bit mantissa as {1, frac}, or 0 when exp==0 (denormals flushed to zero).
- Sign SHALL be sa^sb.
- Exponent difference SHALL be computed 10-bit signed: ea - eb + 127.
REQ-009 DIVIDE SHALL be restoring division, one quotient bit per cycle, bits q[24] down to q[0].
- Remainder starts at ma.
- Each step: if rem >= mb then q bit = 1 and rem -= mb; then rem <<= 1.
- Remainder width: 26 bits.
REQ-010 NORM SHALL normalise the quotient:
- if q[24]=1: mant = q[24:1], exp unchanged;
- else: mant = q[23:0], exp - 1.
- Truncation only; no rounding.
REQ-011 PACK SHALL apply the first matching rule, in this order:
- ea==255 or eb==255 -> 32'h7FC00000.
- a zero and b zero -> 32'h7FC00000.
- b zero -> {sign, 8'hFF, 23'b0}, div_by_zero=1.
- a zero -> 32'h00000000.
- exp >= 255 -> {sign, 8'hFF, 23'b0}.
- exp <= 0 -> 32'h00000000.
- otherwise -> {sign, exp[7:0], mant[22:0]}.
REQ-012 Special-case classification SHALL be latched in UNPACK; DIVIDE SHALL still run its full 25 cycles.

Reset
REQ-013 reset SHALL force, asynchronously:
- state = IDLE;
- busy = 0, flag_done = 0, div_by_zero = 0;
- result = 32'h0;
- all internal registers = 0.
REQ-014 Reset asserted mid-operation SHALL abort the operation with no flag_done pulse; the first start after reset release starts a fresh operation.

Structure
REQ-015 Package fp_pkg SHALL hold:
- BIAS=127, EXP_MAX=8'hFF, QNAN=32'h7FC00000;
- the FSM state encoding.
These constants are shared with the FP multiplier and adder.
REQ-016 A combinational sub-module fp_div_step SHALL implement one restoring iteration: inputs rem[25:0], mb[23:0]; outputs qbit, rem_next[25:0].
REQ-017 The 25-cycle iteration counter SHALL be 5 bits and SHALL be cleared on entry to DIVIDE.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000; flag_done exactly 28 edges after accept, width 1 cycle.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated, not 0x3EAAAAAB); 0xC1000000 / 0x3F000000 (-8/0.5) -> 0xC1800000.
- 0x40A00000 / 0x00000000 -> 0x7F800000 with div_by_zero=1; 0x0 / 0x0 -> 0x7FC00000 with div_by_zero=0; 0x7F800000 / 0x3F800000 -> 0x7FC00000.
- 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow); 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush).
- start re-pulsed during DIVIDE with different a/b -> ignored; original quotient returned; busy high throughout; exactly one flag_done.
- reset pulsed at cycle 10 of DIVIDE -> busy=0, result=0, no flag_done; the next start (9.0/3.0) -> 0x40400000 after 28 edges.
